n_bit_reg: RTL and testbench

- Generic N-bit storage register with a local write enable, a global write enable and a parameterised reset value.
- Basic state element of the datapath, e.g. the latched instruction-memory outputs and pipeline registers.
- Loads `in` on a clock edge only when both enables are high. Otherwise it holds.
- Returns to a programmable constant on reset.

---
 rtl/n_bit_reg.sv | 39 +++
 tb/tb_n_bit_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/n_bit_reg.sv
// rtl/n_bit_reg.sv - N-bit storage register with local/global write enables; optional write-through bypass via NBIT_REG_BYPASS_EN
module n_bit_reg #(
    parameter int          N = 1,
    parameter logic [63:0] R = 64'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         we,
    input  logic         gwe,
`ifdef NBIT_REG_BYPASS_EN
    output logic [N-1:0] out_byp,
`endif
    output logic [N-1:0] out
);

    localparam logic [N-1:0] RST_VAL = N'(R);

    logic         w_load;
    // Initialiser gives a defined power-up value before the first reset.
    logic [N-1:0] r_out = RST_VAL;

    assign w_load = we & gwe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= RST_VAL;
        end else if (w_load) begin
            r_out <= in;
        end
    end

    assign out = r_out;

`ifdef NBIT_REG_BYPASS_EN
    assign out_byp = (w_load & ~rst) ? in : r_out;
`endif

endmodule

// File: tb/tb_n_bit_reg.sv
// tb/tb_n_bit_reg.sv - directed self-checking bench for n_bit_reg (N=16/1/32; bypass checks when NBIT_REG_BYPASS_EN is defined)
module tb_n_bit_reg;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] in16 = '0;
    logic        we16 = 1'b0;
    logic        gwe16 = 1'b0;
    logic [15:0] out16;

    logic        in1 = 1'b0;
    logic        we1 = 1'b0;
    logic        gwe1 = 1'b0;
    logic        out1;

    logic [31:0] in32 = '0;
    logic        we32 = 1'b0;
    logic        gwe32 = 1'b0;
    logic [31:0] out32;

`ifdef NBIT_REG_BYPASS_EN
    logic [15:0] byp16;
    logic        byp1;
    logic [31:0] byp32;
`endif

    int n_checks = 0;
    int n_errors = 0;

    n_bit_reg #(.N(16), .R(64'h00A5)) u_dut16 (
        .clk(clk), .rst(rst), .in(in16), .we(we16), .gwe(gwe16),
`ifdef NBIT_REG_BYPASS_EN
        .out_byp(byp16),
`endif
        .out(out16)
    );

    n_bit_reg #(.N(1), .R(64'h1)) u_dut1 (
        .clk(clk), .rst(rst), .in(in1), .we(we1), .gwe(gwe1),
`ifdef NBIT_REG_BYPASS_EN
        .out_byp(byp1),
`endif
        .out(out1)
    );

    n_bit_reg #(.N(32), .R(64'h0)) u_dut32 (
        .clk(clk), .rst(rst), .in(in32), .we(we32), .gwe(gwe32),
`ifdef NBIT_REG_BYPASS_EN
        .out_byp(byp32),
`endif
        .out(out32)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("powerup16", 64'(out16), 64'h00A5);
        check("powerup1", 64'(out1), 64'h1);

        // Reset with the clock stopped must still take effect.
        in16 = 16'h1111; we16 = 1'b1; gwe16 = 1'b1;
        rst = 1'b1;
        #2;
        check("rst_noclk16", 64'(out16), 64'h00A5);
        check("rst_noclk1", 64'(out1), 64'h1);
        check("rst_noclk32", 64'(out32), 64'h0);
        #3;
        rst = 1'b0;
        we16 = 1'b0; gwe16 = 1'b0;
        #2;
        clk_en = 1'b1;

        for (int i = 0; i < 3; i++) tick();
        check("idle_hold16", 64'(out16), 64'h00A5);

        in16 = 16'h1234; we16 = 1'b1; gwe16 = 1'b1;
        tick();
        check("load_1234", 64'(out16), 64'h1234);

        in16 = 16'hBEEF; we16 = 1'b0; gwe16 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("hold_we0", 64'(out16), 64'h1234);

        we16 = 1'b0; gwe16 = 1'b0;
        tick();
        check("hold_both0", 64'(out16), 64'h1234);

        in16 = 16'hFFFF; we16 = 1'b1; gwe16 = 1'b0;
        tick();
        tick();
        check("hold_gwe0", 64'(out16), 64'h1234);
        gwe16 = 1'b1;
        tick();
        check("load_ffff", 64'(out16), 64'hFFFF);

        // Mid-cycle reset with a load pending: reset wins.
        in16 = 16'h5555; we16 = 1'b1; gwe16 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mid", 64'(out16), 64'h00A5);
        tick();
        tick();
        check("rst_held_edges", 64'(out16), 64'h00A5);
        check("rst_held_n1", 64'(out1), 64'h1);
        #2;
        rst = 1'b0;
        tick();
        check("first_edge_after_rst", 64'(out16), 64'h5555);

        in1 = 1'b0; we1 = 1'b1; gwe1 = 1'b1;
        in32 = 32'hDEADBEEF; we32 = 1'b1; gwe32 = 1'b1;
        tick();
        check("n1_load0", 64'(out1), 64'h0);
        check("n32_load", 64'(out32), 64'hDEADBEEF);
        we32 = 1'b0;
        in32 = 32'h0;
        tick();
        check("n32_hold", 64'(out32), 64'hDEADBEEF);

`ifdef NBIT_REG_BYPASS_EN
        in16 = 16'h0001; we16 = 1'b1; gwe16 = 1'b1;
        tick();
        in16 = 16'h0002;
        #1;
        check("byp_pre_edge", 64'(byp16), 64'h0002);
        check("out_pre_edge", 64'(out16), 64'h0001);
        tick();
        check("out_post_edge", 64'(out16), 64'h0002);
        we16 = 1'b0;
        in16 = 16'h0003;
        #1;
        check("byp_hold", 64'(byp16), 64'h0002);
        we16 = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("byp_rst", 64'(byp16), 64'h00A5);
        rst = 1'b0;
        we16 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
